// File: rtl/n64_vbus_tx.sv
// N64 VI multiplexed video bus source: nVDSYNC plus 7-bit VD (sync word, then R, G, B per pixel).
// Raster, sync, clamp and interlace timing are generated here; active-pixel RGB is pulled over valid/ready.
module n64_vbus_tx #(
  parameter int unsigned H_TOTAL       = 773,
  parameter int unsigned H_SYNC_LEN    = 57,
  parameter int unsigned H_CLAMP_START = 62,
  parameter int unsigned H_CLAMP_LEN   = 16,
  parameter int unsigned H_ACT_START   = 116,
  parameter int unsigned H_ACT_LEN     = 640,
  parameter int unsigned V_TOTAL       = 262,
  parameter int unsigned V_SYNC_LEN    = 3,
  parameter int unsigned V_ACT_START   = 18,
  parameter int unsigned V_ACT_LEN     = 240
) (
  input  logic        VCLK,
  input  logic        nVRST,
  input  logic        en_i,
  input  logic        interlaced_i,
  input  logic        pix_valid_i,
  input  logic [20:0] pix_rgb_i,
  output logic        pix_ready_o,
  output logic        nVDSYNC,
  output logic [6:0]  VD_o,
  output logic        field_o,
  output logic        frame_start_o,
  output logic        underrun_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL + 2);
  localparam int unsigned H_HALF = H_TOTAL / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      phase_reg, phase_next;
  logic [HW-1:0]   hcnt_reg, hcnt_next;
  logic [VW-1:0]   vcnt_reg, vcnt_next;
  logic            field_reg, field_next;
  logic            il_reg, il_next;
  logic [20:0]     rgb_reg, rgb_next;
  logic            ready_reg, ready_next;
  logic            nvdsync_reg, nvdsync_next;
  logic [6:0]      vd_reg, vd_next;
  logic            fstart_reg, fstart_next;
  logic            underrun_reg, underrun_next;

  logic [31:0]     h32, v32, v_last, nxt_h, nxt_v;
  logic            slot_end, line_end, field_end, nxt_active;
  logic            nhsync, nclamp, ncsync, vs_act, vs_half;
  logic [6:0]      chan [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = rgb_reg[20-7*gi -: 7];
    end
  endgenerate

  assign h32       = 32'(hcnt_reg);
  assign v32       = 32'(vcnt_reg);
  // Odd field of an interlaced frame carries one extra line.
  assign v_last    = field_reg ? 32'(V_TOTAL) : 32'(V_TOTAL - 1);
  assign slot_end  = (phase_reg == 2'd3);
  assign line_end  = slot_end && (h32 == 32'(H_TOTAL - 1));
  assign field_end = line_end && (v32 == v_last);

  assign nhsync = !(h32 < H_SYNC_LEN);
  assign nclamp = !((h32 >= H_CLAMP_START) && (h32 < H_CLAMP_START + H_CLAMP_LEN));

  // Odd-field vsync starts half a line late and lasts the same number of lines.
  assign vs_half = ((v32 == 32'd0) && (h32 >= H_HALF)) ||
                   ((v32 > 32'd0) && (v32 < V_SYNC_LEN)) ||
                   ((v32 == 32'(V_SYNC_LEN)) && (h32 < H_HALF));
  assign vs_act  = field_reg ? vs_half : (v32 < V_SYNC_LEN);
  assign ncsync  = vs_act ? ~nhsync : nhsync;

  // Position of the slot that follows the current one, used to request its pixel.
  assign nxt_h = (h32 == 32'(H_TOTAL - 1)) ? 32'd0 : h32 + 32'd1;
  assign nxt_v = (h32 == 32'(H_TOTAL - 1)) ? ((v32 == v_last) ? 32'd0 : v32 + 32'd1) : v32;
  assign nxt_active = (nxt_h >= H_ACT_START) && (nxt_h < H_ACT_START + H_ACT_LEN) &&
                      (nxt_v >= V_ACT_START) && (nxt_v < V_ACT_START + V_ACT_LEN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (en_i) state_next = ST_RUN;
      ST_RUN:  if (!en_i) state_next = field_end ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (en_i)           state_next = ST_RUN;
        else if (field_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_next    = phase_reg;
    hcnt_next     = hcnt_reg;
    vcnt_next     = vcnt_reg;
    field_next    = field_reg;
    il_next       = il_reg;
    rgb_next      = rgb_reg;
    ready_next    = 1'b0;
    nvdsync_next  = 1'b1;
    vd_next       = 7'd0;
    fstart_next   = 1'b0;
    underrun_next = underrun_reg;

    if (state_reg == ST_IDLE) begin
      phase_next = 2'd0;
      hcnt_next  = '0;
      vcnt_next  = '0;
      if (en_i) begin
        il_next     = interlaced_i;
        field_next  = 1'b0;
        rgb_next    = '0;
        fstart_next = 1'b1;
      end
    end else begin
      phase_next = phase_reg + 2'd1;
      ready_next = (phase_reg == 2'd2) && nxt_active;
      case (phase_reg)
        2'd0: begin
          nvdsync_next = 1'b0;
          vd_next      = {3'b000, ~vs_act, nclamp, nhsync, ncsync};
        end
        2'd1:    vd_next = chan[0];
        2'd2:    vd_next = chan[1];
        default: vd_next = chan[2];
      endcase

      if (slot_end) begin
        // A starved request still consumes the slot, which then goes out black.
        rgb_next = (ready_reg && pix_valid_i) ? pix_rgb_i : 21'd0;
        if (ready_reg && !pix_valid_i) underrun_next = 1'b1;
        if (line_end) begin
          hcnt_next = '0;
          vcnt_next = vcnt_reg + 1'b1;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
        if (field_end) begin
          vcnt_next   = '0;
          field_next  = (il_reg && interlaced_i) ? ~field_reg : 1'b0;
          il_next     = interlaced_i;
          fstart_next = (state_next != ST_IDLE);
        end
      end
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= 2'd0;
      hcnt_reg     <= '0;
      vcnt_reg     <= '0;
      field_reg    <= 1'b0;
      il_reg       <= 1'b0;
      rgb_reg      <= '0;
      ready_reg    <= 1'b0;
      nvdsync_reg  <= 1'b1;
      vd_reg       <= 7'd0;
      fstart_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      hcnt_reg     <= hcnt_next;
      vcnt_reg     <= vcnt_next;
      field_reg    <= field_next;
      il_reg       <= il_next;
      rgb_reg      <= rgb_next;
      ready_reg    <= ready_next;
      nvdsync_reg  <= nvdsync_next;
      vd_reg       <= vd_next;
      fstart_reg   <= fstart_next;
      underrun_reg <= underrun_next;
    end
  end

  assign pix_ready_o   = ready_reg;
  assign nVDSYNC       = nvdsync_reg;
  assign VD_o          = vd_reg;
  assign field_o       = field_reg;
  assign frame_start_o = fstart_reg;
  assign underrun_o    = underrun_reg;

endmodule

// File: tb/tb_n64_vbus_tx.sv
// Directed bench for n64_vbus_tx on a shrunken 8-slot x 6-line raster.
// Each scenario task compares bus, handshake and status outputs cycle by cycle against hand-derived values.
module tb_n64_vbus_tx;

  logic        VCLK = 1'b0;
  logic        nVRST = 1'b0;
  logic        en_i = 1'b0;
  logic        interlaced_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [20:0] pix_rgb_i = 21'd0;
  logic        pix_ready_o;
  logic        nVDSYNC;
  logic [6:0]  VD_o;
  logic        field_o;
  logic        frame_start_o;
  logic        underrun_o;

  int checks = 0;
  int errors = 0;

  always #5 VCLK = ~VCLK;

  n64_vbus_tx #(
    .H_TOTAL(8), .H_SYNC_LEN(2), .H_ACT_START(4), .H_ACT_LEN(3),
    .V_TOTAL(6), .V_SYNC_LEN(1), .V_ACT_START(2), .V_ACT_LEN(2)
  ) dut (
    .VCLK(VCLK), .nVRST(nVRST), .en_i(en_i), .interlaced_i(interlaced_i),
    .pix_valid_i(pix_valid_i), .pix_rgb_i(pix_rgb_i), .pix_ready_o(pix_ready_o),
    .nVDSYNC(nVDSYNC), .VD_o(VD_o), .field_o(field_o),
    .frame_start_o(frame_start_o), .underrun_o(underrun_o)
  );

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  function automatic logic is_act(input int h, input int v);
    return (h >= 4) && (h < 7) && (v >= 2) && (v < 4);
  endfunction

  // Word visible in field cycle c was produced in cycle c-1 (slot (c-1)/4, phase (c-1)%4).
  function automatic logic [6:0] exp_vd(input int c, input int drop_slot, input logic f1);
    int j, ph, s, h, v;
    logic vs, nhs, ncs;
    logic [6:0] r;
    j = c - 1; ph = j % 4; s = j / 4; h = s % 8; v = s / 8;
    if (ph == 0) begin
      vs  = f1 ? (((v == 0) && (h >= 4)) || ((v == 1) && (h < 4))) : (v < 1);
      nhs = (h >= 2);
      ncs = vs ? ~nhs : nhs;
      r   = {3'b000, ~vs, 1'b1, nhs, ncs};
    end else if (!is_act(h, v) || (s == drop_slot)) begin
      r = 7'h00;
    end else if (ph == 1) begin
      r = 7'h55;
    end else if (ph == 2) begin
      r = 7'h2A;
    end else begin
      r = 7'h7F;
    end
    return r;
  endfunction

  function automatic logic exp_ready(input int c);
    int ns;
    ns = c / 4 + 1;
    return ((c % 4) == 3) && is_act(ns % 8, ns / 8);
  endfunction

  task automatic test_reset();
    nVRST = 1'b0; en_i = 1'b0;
    repeat (3) tick();
    checks++; if (nVDSYNC !== 1'b1) begin errors++; $display("FAIL reset_nVDSYNC: got %b want 1", nVDSYNC); end
    checks++; if (VD_o !== 7'h00) begin errors++; $display("FAIL reset_VD: got %h want 00", VD_o); end
    checks++; if (pix_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pix_ready_o); end
    checks++; if (field_o !== 1'b0) begin errors++; $display("FAIL reset_field: got %b want 0", field_o); end
    checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun_o); end
    $display("reset: outputs checked");
  endtask

  task automatic test_progressive();
    int pulses;
    logic [6:0] e;
    pix_valid_i = 1'b1; pix_rgb_i = {7'h55, 7'h2A, 7'h7F}; interlaced_i = 1'b0;
    nVRST = 1'b1; en_i = 1'b1;
    tick();
    checks++; if (frame_start_o !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b want 1", frame_start_o); end
    checks++; if (nVDSYNC !== 1'b1) begin errors++; $display("FAIL enable_edge_bus: got nVDSYNC=%b want 1", nVDSYNC); end
    pulses = 0;
    for (int c = 1; c <= 192; c++) begin
      tick();
      e = exp_vd(c, -1, 1'b0);
      if (c == 1) begin
        checks++; if (VD_o !== 7'h05) begin errors++; $display("FAIL first_sync_word: got %h want 05", VD_o); end
      end
      checks++; if (nVDSYNC !== (((c - 1) % 4) != 0)) begin errors++; $display("FAIL prog_nVDSYNC c=%0d: got %b", c, nVDSYNC); end
      checks++; if (VD_o !== e) begin errors++; $display("FAIL prog_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (pix_ready_o !== exp_ready(c)) begin errors++; $display("FAIL prog_ready c=%0d: got %b want %b", c, pix_ready_o, exp_ready(c)); end
      checks++; if (frame_start_o !== (c == 192)) begin errors++; $display("FAIL prog_frame_start c=%0d: got %b", c, frame_start_o); end
      checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL prog_underrun c=%0d: got %b want 0", c, underrun_o); end
      if (pix_ready_o === 1'b1) pulses++;
    end
    checks++; if (pulses !== 6) begin errors++; $display("FAIL prog_ready_pulses: got %0d want 6", pulses); end
    checks++; if (field_o !== 1'b0) begin errors++; $display("FAIL prog_field: got %b want 0", field_o); end
    $display("progressive field: %0d ready pulses", pulses);
  endtask

  task automatic test_underrun();
    logic [6:0] e;
    for (int c = 1; c <= 192; c++) begin
      tick();
      e = exp_vd(c, 21, 1'b0);
      checks++; if (VD_o !== e) begin errors++; $display("FAIL urun_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (pix_ready_o !== exp_ready(c)) begin errors++; $display("FAIL urun_ready c=%0d: got %b", c, pix_ready_o); end
      checks++; if (underrun_o !== (c >= 84)) begin errors++; $display("FAIL urun_flag c=%0d: got %b", c, underrun_o); end
      checks++; if (frame_start_o !== (c == 192)) begin errors++; $display("FAIL urun_frame_start c=%0d: got %b", c, frame_start_o); end
      pix_valid_i = (c != 83);
      if (c == 100) en_i = 1'b0;
      if (c == 102) en_i = 1'b1;
    end
    $display("underrun field: flag=%b", underrun_o);
  endtask

  task automatic test_stop();
    logic [6:0] e;
    for (int c = 1; c <= 191; c++) begin
      tick();
      e = exp_vd(c, -1, 1'b0);
      checks++; if (VD_o !== e) begin errors++; $display("FAIL stop_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (nVDSYNC !== (((c - 1) % 4) != 0)) begin errors++; $display("FAIL stop_nVDSYNC c=%0d: got %b", c, nVDSYNC); end
      if (c == 50) en_i = 1'b0;
    end
    for (int c = 192; c <= 200; c++) begin
      tick();
      checks++; if (nVDSYNC !== 1'b1) begin errors++; $display("FAIL idle_nVDSYNC c=%0d: got %b want 1", c, nVDSYNC); end
      checks++; if (VD_o !== 7'h00) begin errors++; $display("FAIL idle_vd c=%0d: got %h want 00", c, VD_o); end
      checks++; if (pix_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready c=%0d: got %b want 0", c, pix_ready_o); end
      checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL idle_frame_start c=%0d: got %b want 0", c, frame_start_o); end
    end
    checks++; if (underrun_o !== 1'b1) begin errors++; $display("FAIL idle_underrun_sticky: got %b want 1", underrun_o); end
    interlaced_i = 1'b1; en_i = 1'b1;
    tick();
    checks++; if (frame_start_o !== 1'b1) begin errors++; $display("FAIL restart_frame_start: got %b want 1", frame_start_o); end
    $display("stop: field completed, bus idled, restarted");
  endtask

  task automatic test_interlace();
    logic [6:0] e;
    for (int c = 1; c <= 192; c++) begin
      tick();
      e = exp_vd(c, -1, 1'b0);
      if (c == 1) begin
        checks++; if (VD_o !== 7'h05) begin errors++; $display("FAIL restart_sync_word: got %h want 05", VD_o); end
      end
      checks++; if (VD_o !== e) begin errors++; $display("FAIL il0_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (field_o !== (c == 192)) begin errors++; $display("FAIL il0_field c=%0d: got %b", c, field_o); end
      checks++; if (frame_start_o !== (c == 192)) begin errors++; $display("FAIL il0_frame_start c=%0d: got %b", c, frame_start_o); end
    end
    for (int c = 1; c <= 224; c++) begin
      tick();
      e = exp_vd(c, -1, 1'b1);
      if (c == 13) begin
        checks++; if (VD_o !== 7'h0F) begin errors++; $display("FAIL il1_presync_h3: got %h want 0F", VD_o); end
      end
      if (c == 17) begin
        checks++; if (VD_o !== 7'h06) begin errors++; $display("FAIL il1_vsync_fall_h4: got %h want 06", VD_o); end
      end
      checks++; if (VD_o !== e) begin errors++; $display("FAIL il1_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (pix_ready_o !== exp_ready(c)) begin errors++; $display("FAIL il1_ready c=%0d: got %b", c, pix_ready_o); end
      checks++; if (field_o !== (c != 224)) begin errors++; $display("FAIL il1_field c=%0d: got %b", c, field_o); end
      checks++; if (frame_start_o !== (c == 224)) begin errors++; $display("FAIL il1_frame_start c=%0d: got %b", c, frame_start_o); end
    end
    $display("interlace: fields of 192 and 224 cycles");
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    repeat (274) tick();
    checks++; if (VD_o !== 7'h55) begin errors++; $display("FAIL pre_reset_vd: got %h want 55", VD_o); end
    checks++; if (field_o !== 1'b1) begin errors++; $display("FAIL pre_reset_field: got %b want 1", field_o); end
    nVRST = 1'b0;
    #1;
    checks++; if (nVDSYNC !== 1'b1) begin errors++; $display("FAIL arst_nVDSYNC: got %b want 1", nVDSYNC); end
    checks++; if (VD_o !== 7'h00) begin errors++; $display("FAIL arst_vd: got %h want 00", VD_o); end
    checks++; if (pix_ready_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b want 0", pix_ready_o); end
    checks++; if (field_o !== 1'b0) begin errors++; $display("FAIL arst_field: got %b want 0", field_o); end
    checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL arst_frame_start: got %b want 0", frame_start_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL arst_underrun: got %b want 0", underrun_o); end
    #2;
    nVRST = 1'b1; interlaced_i = 1'b0;
    tick();
    checks++; if (frame_start_o !== 1'b1) begin errors++; $display("FAIL arst_restart_frame_start: got %b want 1", frame_start_o); end
    for (int c = 1; c <= 192; c++) begin
      tick();
      e = exp_vd(c, -1, 1'b0);
      checks++; if (VD_o !== e) begin errors++; $display("FAIL arst_vd c=%0d: got %h want %h", c, VD_o, e); end
      checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL arst_urun c=%0d: got %b want 0", c, underrun_o); end
      checks++; if (frame_start_o !== (c == 192)) begin errors++; $display("FAIL arst_fs c=%0d: got %b", c, frame_start_o); end
    end
    $display("async reset: cleared and restarted");
  endtask

  initial begin
    test_reset();
    test_progressive();
    test_underrun();
    test_stop();
    test_interlace();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
